adc_readout_scheduler: RTL and testbench

ADC_READOUT_SCHEDULER -- requirements
Module: adc_readout_scheduler

---
 rtl/adc_readout_scheduler_pkg.sv | 16 +
 rtl/next_channel_pick.sv | 23 ++
 rtl/adc_readout_scheduler.sv | 136 +++++++++++++
 tb/tb_adc_readout_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_readout_scheduler_pkg.sv
// Shared definitions for the ADC readout scheduler: FSM encoding, header magic and gap length.
package rfsoc_config;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HEADER,
        ST_STREAM,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [15:0] HEADER_MAGIC = 16'hADC0;
    localparam int          GAP_LEN      = 2;

endpackage

// File: rtl/next_channel_pick.sv
// Priority encoder: lowest set mask bit at or above ptr, with a found flag.
module next_channel_pick #(
    parameter int NUM_CHANNELS = 16
) (
    input  logic [NUM_CHANNELS-1:0] mask,
    input  logic [3:0]              ptr,
    output logic [3:0]              index,
    output logic                    found
);

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(ptr))) begin
                index = 4'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_readout_scheduler.sv
// Walks enabled capture channels in order, emitting a header plus the channel's words to the PS stream.
module adc_readout_scheduler
    import rfsoc_config::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic [COUNT_WIDTH-1:0]  words_per_channel,
    output logic [3:0]              ch_sel,
    output logic                    ch_readout_en,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done,
    output state_t                  fsm_state
);

    // Streams follow AXIS rules: a beat transfers on the rising edge where tvalid and tready are both high.
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [COUNT_WIDTH-1:0]  wpc_q;
    logic [COUNT_WIDTH-1:0]  count;
    logic [3:0]              ptr;
    logic [1:0]              gap_cnt;
    logic [3:0]              pick_idx;
    logic                    pick_found;
    logic                    last_word;

    next_channel_pick #(.NUM_CHANNELS(NUM_CHANNELS)) u_pick (
        .mask  (mask_q),
        .ptr   (ptr),
        .index (pick_idx),
        .found (pick_found)
    );

    assign last_word = (count == wpc_q - COUNT_WIDTH'(1));
    assign busy      = (fsm_state != ST_IDLE);
    assign done      = (fsm_state == ST_DONE) && !abort;

    // Abort silences the stream in the same cycle it is seen.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        ch_readout_en = 1'b0;
        case (fsm_state)
            ST_HEADER: if (!abort) begin
                ch_readout_en = 1'b1;
                m_axis_tdata  = DATA_WIDTH'({HEADER_MAGIC, 12'h000, ch_sel});
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (wpc_q == '0);
            end
            ST_STREAM: if (!abort) begin
                ch_readout_en = 1'b1;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = last_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_state <= ST_IDLE;
            mask_q    <= '0;
            wpc_q     <= '0;
            count     <= '0;
            ptr       <= '0;
            ch_sel    <= '0;
            gap_cnt   <= '0;
        end else if (abort && fsm_state != ST_IDLE) begin
            fsm_state <= ST_IDLE;
            count     <= '0;
            gap_cnt   <= '0;
        end else begin
            case (fsm_state)
                ST_IDLE: if (start) begin
                    mask_q    <= channel_mask;
                    wpc_q     <= words_per_channel;
                    ptr       <= '0;
                    fsm_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (pick_found) begin
                        ch_sel    <= pick_idx;
                        fsm_state <= ST_HEADER;
                    end else begin
                        fsm_state <= ST_DONE;
                    end
                end
                ST_HEADER: begin
                    count <= '0;
                    if (m_axis_tready)
                        fsm_state <= (wpc_q == '0) ? ST_GAP : ST_STREAM;
                end
                ST_STREAM: if (s_axis_tvalid && m_axis_tready) begin
                    if (last_word) begin
                        count     <= '0;
                        fsm_state <= ST_GAP;
                    end else begin
                        count <= count + COUNT_WIDTH'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 2'(GAP_LEN - 1)) begin
                        gap_cnt <= '0;
                        if (ch_sel == 4'(NUM_CHANNELS - 1)) begin
                            fsm_state <= ST_DONE;
                        end else begin
                            ptr       <= ch_sel + 4'd1;
                            fsm_state <= ST_SCAN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                ST_DONE: fsm_state <= ST_IDLE;
                default: fsm_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_readout_scheduler.sv
// Randomised bench for adc_readout_scheduler against a packet-level model of each readout pass.
module tb_adc_readout_scheduler;
    import rfsoc_config::*;

    localparam int NCH = 16;
    localparam int DW  = 32;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NCH-1:0] channel_mask = '0;
    logic [CW-1:0] words_per_channel = '0;
    logic [3:0]    ch_sel;
    logic          ch_readout_en;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    state_t        fsm_state;

    adc_readout_scheduler #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .channel_mask      (channel_mask),
        .words_per_channel (words_per_channel),
        .ch_sel            (ch_sel),
        .ch_readout_en     (ch_readout_en),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .busy              (busy),
        .done              (done),
        .fsm_state         (fsm_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard: {tlast, tdata} per PS beat.
    logic [DW:0] exp_q[$];
    logic [DW:0] obs_q[$];
    int          obs_cyc[$];

    int       cyc = 0;
    int       done_cnt = 0;
    int       done_cyc = -1;
    int       en_cnt = 0;
    int       start_cyc = -1;
    int       done_base = 0;
    int       src_idx = 0;
    bit       s_hold = 1'b0;
    bit       rdy_rand = 1'b0;
    logic [7:0] salt = 8'h00;

    function automatic logic [DW-1:0] src_word(input int ch, input int idx);
        logic [7:0]  c;
        logic [15:0] w;
        c = 8'(ch);
        w = 16'(idx);
        return {c, salt, w};
    endfunction

    function automatic logic [DW-1:0] hdr_word(input int ch);
        logic [3:0] c;
        c = 4'(ch);
        return {16'hADC0, 12'h000, c};
    endfunction

    // Packet-level model: for every enabled channel in ascending order, a header then the channel's words.
    task automatic build_exp(input logic [NCH-1:0] m, input int w);
        exp_q.delete();
        for (int ch = 0; ch < NCH; ch++) begin
            if (m[ch]) begin
                exp_q.push_back({(w == 0), hdr_word(ch)});
                for (int i = 0; i < w; i++)
                    exp_q.push_back({(i == w - 1), src_word(ch, i)});
            end
        end
    endtask

    // Capture-buffer source plus PS-side sink and monitor; drives at negedge, samples 1 ns later.
    always @(negedge clk) begin
        s_axis_tvalid = s_hold ? 1'b1 : ($urandom_range(0, 3) != 0);
        s_axis_tdata  = src_word(int'(ch_sel), src_idx);
        m_axis_tready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
        if (m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back({m_axis_tlast, m_axis_tdata});
            obs_cyc.push_back(cyc);
        end
        if (s_axis_tvalid && s_axis_tready) src_idx++;
        s_hold = s_axis_tvalid && !s_axis_tready;
        if (!ch_readout_en) begin
            src_idx = 0;
            s_hold  = 1'b0;
        end
        if (ch_readout_en) en_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start) start_cyc = cyc;
        cyc++;
    end

    task automatic start_pass(input logic [NCH-1:0] m, input int w, input bit rr);
        @(negedge clk);
        obs_q.delete();
        obs_cyc.delete();
        salt = 8'($urandom);
        rdy_rand = rr;
        build_exp(m, w);
        done_base = done_cnt;
        channel_mask = m;
        words_per_channel = CW'(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        channel_mask = NCH'($urandom);
        words_per_channel = CW'($urandom_range(0, 20));
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && done_cnt == done_base; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt == done_base) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_beats(input int n, input string name);
        for (int i = 0; i < 500 && obs_q.size() < n; i++) @(negedge clk);
        checks++;
        if (obs_q.size() < n) begin
            errors++;
            $display("FAIL %s_beats: got %0d beats, needed %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({ch_sel, ch_readout_en, m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done} !== 10'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {ch_sel, ch_readout_en, m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done});
        end
        checks++;
        if (fsm_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        start_pass(16'h0005, 4, 1'b0);
        wait_done(200, "basic");
        checks++;
        if (obs_q.size() != 10) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 10", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 10) begin
            checks++;
            if (obs_cyc[5] - obs_cyc[4] != 4) begin
                errors++;
                $display("FAIL basic_gap: got %0d cycles expected 4", obs_cyc[5] - obs_cyc[4]);
            end
            checks++;
            if (done_cyc - obs_cyc[9] != 4) begin
                errors++;
                $display("FAIL basic_done_time: got %0d expected 4", done_cyc - obs_cyc[9]);
            end
        end
        checks++;
        if (done_cnt - done_base != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d expected 1", done_cnt - done_base);
        end
    endtask

    task automatic test_empty_mask();
        int en0;
        en0 = en_cnt;
        start_pass('0, 5, 1'b0);
        wait_done(20, "empty");
        checks++;
        if (done_cyc - start_cyc != 2) begin
            errors++;
            $display("FAIL empty_done_time: got %0d expected 2", done_cyc - start_cyc);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL empty_beats: got %0d expected 0", obs_q.size());
        end
        checks++;
        if (en_cnt != en0) begin
            errors++;
            $display("FAIL empty_readout_en: got %0d cycles expected 0", en_cnt - en0);
        end
    endtask

    task automatic test_zero_words();
        start_pass(16'h8000, 0, 1'b0);
        wait_done(50, "zero_wpc");
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL zero_wpc_count: got %0d expected 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {1'b1, 32'hADC0000F}) begin
                errors++;
                $display("FAIL zero_wpc_beat: got %h expected %h", obs_q[0], {1'b1, 32'hADC0000F});
            end
            checks++;
            if (done_cyc - obs_cyc[0] != 3) begin
                errors++;
                $display("FAIL zero_wpc_done_time: got %0d expected 3", done_cyc - obs_cyc[0]);
            end
        end
    endtask

    task automatic test_stress();
        int lasts;
        start_pass(16'hFFFF, 8, 1'b1);
        wait_done(3000, "stress");
        lasts = 0;
        foreach (obs_q[i]) if (obs_q[i][DW]) lasts++;
        checks++;
        if (obs_q.size() != 144 || lasts != 16) begin
            errors++;
            $display("FAIL stress_shape: got %0d beats %0d lasts expected 144 and 16", obs_q.size(), lasts);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stress_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        start_pass(16'h0008, 6, 1'b0);
        wait_beats(3, "abort");
        @(negedge clk);
        abort = 1'b1;
        #2;
        checks++;
        if ({ch_readout_en, m_axis_tvalid, s_axis_tready} !== 3'b000) begin
            errors++;
            $display("FAIL abort_quiet: got %b expected 000", {ch_readout_en, m_axis_tvalid, s_axis_tready});
        end
        @(negedge clk);
        abort = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || fsm_state !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b state=%0d expected busy=0 state=%0d", busy, fsm_state, ST_IDLE);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt != done_base) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - done_base);
        end
        start_pass(16'h0009, 2, 1'b0);
        wait_done(100, "abort_restart");
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL abort_restart_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_restart_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_abort_same();
        @(negedge clk);
        abort = 1'b1;
        start_pass(16'h0002, 1, 1'b0);
        abort = 1'b0;
        wait_done(50, "start_abort");
        checks++;
        if (obs_q.size() != 2 || (obs_q.size() == 2 && (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]))) begin
            errors++;
            $display("FAIL start_abort_pass: got %0d beats expected 2 matching beats", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        start_pass(16'h0003, 3, 1'b1);
        wait_beats(2, "ignored_start");
        @(negedge clk);
        channel_mask = 16'hFFFF;
        words_per_channel = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, "ignored_start");
        repeat (5) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size() || done_cnt - done_base != 1) begin
            errors++;
            $display("FAIL ignored_start_shape: got %0d beats %0d dones expected %0d and 1",
                     obs_q.size(), done_cnt - done_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ignored_start_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_pass(16'hFFFF, 8, 1'b0);
        wait_beats(3, "rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        checks++;
        if ({ch_sel, ch_readout_en, m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done} !== 10'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {ch_sel, ch_readout_en, m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done});
        end
        rst = 1'b1;
        start_pass(16'h0010, 2, 1'b1);
        wait_done(100, "rst_fresh");
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_fresh_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_fresh_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_mask();
        test_zero_words();
        test_stress();
        test_abort();
        test_start_abort_same();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
